conv_pixel_streamer: RTL and testbench

//  Source end of the convolution engine's pixel interface. Holds one IMG_W x IMG_H
//  8-bit frame in an internal buffer, loaded by the host through a simple write port.
//  On a host "go" it pulses start_signal, then streams the frame in raster order on

---
 rtl/conv_pixel_streamer.sv | 218 +++++++++++++++++++++
 tb/tb_conv_pixel_streamer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pixel_streamer.sv
// Frame-buffered pixel source for the convolution engine: host loads a frame, go streams it raster-order.
// Latency: go@T -> start_signal@T+1 -> pixel 0 @T+2, one pixel every GAP+1 cycles thereafter.
// Backpressure: none on the stream (engine must accept every valid); host writes/go are ignored while busy.
module conv_pixel_streamer #(
    parameter int IMG_W   = 32,
    parameter int IMG_H   = 32,
    parameter int PIX_W   = 8,
    parameter int GAP     = 0,
    parameter int TIMEOUT = 4096,
    localparam int N_PIX  = IMG_W * IMG_H,
    localparam int ADDR_W = $clog2(N_PIX)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic              go,
    output logic              busy,
    output logic              frame_done,
    output logic              timeout_err,
    output logic [15:0]       res_count,
    output logic              start_signal,
    output logic              pixel_valid,
    output logic [PIX_W-1:0]  pixel_in,
    input  logic              result_valid,
    input  logic              done_signal
);

    localparam int N_RES = (IMG_W - 2) * (IMG_H - 2);
    localparam int CNT_W = ADDR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [CNT_W-1:0] N_PIX_C   = CNT_W'(N_PIX);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_WAIT_RES,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [PIX_W-1:0]  mem [N_PIX];
    logic [PIX_W-1:0]  ram_q;
    logic [ADDR_W-1:0] rd_addr;

    logic [CNT_W-1:0]  pix_cnt, pix_cnt_nxt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [TMR_W-1:0]  tmr;
    logic [15:0]       res_count_nxt;

    logic go_acc;
    logic emit;
    logic cnt_en;
    logic res_hit;
    logic tmo_hit;
    logic wait_ok;

    // ------------------------------------------------------------------
    // Control terms
    // ------------------------------------------------------------------
    always_comb begin
        go_acc  = (state == S_IDLE) && go;
        emit    = (state == S_START) ||
                  ((state == S_STREAM) && (gap_cnt == '0) && (pix_cnt < N_PIX_C));
        cnt_en  = result_valid &&
                  ((state == S_START) || (state == S_STREAM) || (state == S_WAIT_RES));
        tmo_hit = (tmr == TMR_LAST) && !result_valid;
    end

    always_comb begin
        res_count_nxt = res_count;
        if (go_acc) begin
            res_count_nxt = '0;
        end else if (cnt_en && (res_count != 16'hFFFF)) begin
            res_count_nxt = res_count + 16'd1;
        end
    end

    // Completion looks at the post-increment count so the final pulse ends the frame next cycle.
    always_comb begin
        res_hit = 32'(res_count_nxt) >= N_RES;
        wait_ok = done_signal || res_hit;
    end

    // pix_cnt_nxt drives the RAM read so ram_q always holds the next pixel to emit.
    always_comb begin
        pix_cnt_nxt = pix_cnt;
        if (state == S_IDLE) begin
            pix_cnt_nxt = '0;
        end else if (emit) begin
            pix_cnt_nxt = pix_cnt + 1'b1;
        end
        rd_addr = pix_cnt_nxt[ADDR_W-1:0];
    end

    // ------------------------------------------------------------------
    // Frame buffer (not reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en && (state == S_IDLE) && (32'(wr_addr) < N_PIX)) begin
            mem[wr_addr] <= wr_data;
        end
        ram_q <= mem[rd_addr];
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (go) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (pix_cnt == N_PIX_C) begin
                    state_nxt = S_WAIT_RES;
                end
            end
            S_WAIT_RES: begin
                if (wait_ok || tmo_hit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy         = 1'b0;
        start_signal = 1'b0;
        frame_done   = 1'b0;
        unique case (state)
            S_START: begin
                busy         = 1'b1;
                start_signal = 1'b1;
            end
            S_STREAM,
            S_WAIT_RES: begin
                busy = 1'b1;
            end
            S_DONE: begin
                frame_done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt     <= '0;
            gap_cnt     <= '0;
            tmr         <= '0;
            res_count   <= '0;
            timeout_err <= 1'b0;
            pixel_valid <= 1'b0;
            pixel_in    <= '0;
        end else begin
            pix_cnt   <= pix_cnt_nxt;
            res_count <= res_count_nxt;

            if (emit) begin
                gap_cnt <= GAP_RELOAD;
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end

            // Timer only runs in WAIT_RES and restarts on each result strobe.
            if ((state != S_WAIT_RES) || result_valid) begin
                tmr <= '0;
            end else begin
                tmr <= tmr + 1'b1;
            end

            if (go_acc) begin
                timeout_err <= 1'b0;
            end else if ((state == S_WAIT_RES) && !wait_ok && tmo_hit) begin
                timeout_err <= 1'b1;
            end

            pixel_valid <= emit;
            pixel_in    <= emit ? ram_q : '0;
        end
    end

endmodule

// File: tb/tb_conv_pixel_streamer.sv
// Directed bench for conv_pixel_streamer: one GAP=0 and one GAP=2 instance, both TIMEOUT=64.
`timescale 1ns/1ps
module tb_conv_pixel_streamer;

    localparam int NP = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        we0, go0, rv0, ds0;
    logic [9:0]  wa0;
    logic [7:0]  wd0;
    logic        busy0, fd0, te0, st0, pv0;
    logic [15:0] rc0;
    logic [7:0]  pi0;

    logic        we2, go2, rv2, ds2;
    logic [9:0]  wa2;
    logic [7:0]  wd2;
    logic        busy2, fd2, te2, st2, pv2;
    logic [15:0] rc2;
    logic [7:0]  pi2;

    logic [7:0] img0 [NP];
    logic [7:0] img2 [NP];

    int errors = 0;
    int checks = 0;

    conv_pixel_streamer #(.IMG_W(32), .IMG_H(32), .PIX_W(8), .GAP(0), .TIMEOUT(64)) u_d0 (
        .clk(clk), .rst(rst), .wr_en(we0), .wr_addr(wa0), .wr_data(wd0), .go(go0),
        .busy(busy0), .frame_done(fd0), .timeout_err(te0), .res_count(rc0),
        .start_signal(st0), .pixel_valid(pv0), .pixel_in(pi0),
        .result_valid(rv0), .done_signal(ds0)
    );

    conv_pixel_streamer #(.IMG_W(32), .IMG_H(32), .PIX_W(8), .GAP(2), .TIMEOUT(64)) u_d2 (
        .clk(clk), .rst(rst), .wr_en(we2), .wr_addr(wa2), .wr_data(wd2), .go(go2),
        .busy(busy2), .frame_done(fd2), .timeout_err(te2), .res_count(rc2),
        .start_signal(st2), .pixel_valid(pv2), .pixel_in(pi2),
        .result_valid(rv2), .done_signal(ds2)
    );

    // Runs one frame on the GAP=0 instance, checking start and every pixel cycle against img0.
    task automatic stream0(input string tag, input int rv_lo, input int rv_hi, input int ds_k,
                           input bit misuse, output int done_k, output logic [15:0] rc_d,
                           output logic te_d, output logic busy_d, output int starts);
        logic       exp_v;
        logic [7:0] exp_p;
        done_k = -1; starts = 0; rc_d = '0; te_d = 1'b0; busy_d = 1'b1;
        @(negedge clk);
        go0 = 1'b1;
        for (int k = 1; k <= 1300 && done_k < 0; k++) begin
            @(negedge clk);
            if (st0 === 1'b1) starts++;
            checks++;
            if (st0 !== (k == 1)) begin
                errors++;
                $display("FAIL %s start k=%0d got=%b exp=%b", tag, k, st0, (k == 1));
            end
            exp_v = (k >= 2 && k <= NP + 1);
            exp_p = 8'h00;
            if (exp_v) exp_p = img0[k-2];
            checks++;
            if (pv0 !== exp_v || pi0 !== exp_p) begin
                errors++;
                $display("FAIL %s pixel k=%0d got v=%b d=%h exp v=%b d=%h", tag, k, pv0, pi0, exp_v, exp_p);
            end
            if (fd0 === 1'b1) begin
                done_k = k; rc_d = rc0; te_d = te0; busy_d = busy0;
            end
            go0 = misuse && k >= 100 && k < 110;
            we0 = misuse && k >= 100 && k < 110;
            wa0 = 10'(k);
            wd0 = 8'h77;
            rv0 = (k >= rv_lo && k <= rv_hi);
            ds0 = (k == ds_k);
        end
        go0 = 1'b0; we0 = 1'b0; rv0 = 1'b0; ds0 = 1'b0;
        if (done_k < 0) begin
            checks++; errors++;
            $display("FAIL %s no frame_done within 1300 cycles", tag);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {we0, go0, rv0, ds0, we2, go2, rv2, ds2} = '0;
        wa0 = '0; wd0 = '0; wa2 = '0; wd2 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy0, fd0, te0, st0, pv0, pi0, rc0} !== 29'd0) begin
            errors++;
            $display("FAIL reset_d0 got=%h exp=0", {busy0, fd0, te0, st0, pv0, pi0, rc0});
        end
        checks++;
        if ({busy2, fd2, te2, st2, pv2, pi2, rc2} !== 29'd0) begin
            errors++;
            $display("FAIL reset_d2 got=%h exp=0", {busy2, fd2, te2, st2, pv2, pi2, rc2});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy0=%b busy2=%b exp 0", busy0, busy2);
        end
    endtask

    task automatic load_bufs();
        for (int i = 0; i < NP; i++) begin
            img0[i] = ((i % 32) < 16) ? 8'h00 : 8'hFF;
            img2[i] = (((i % 32) + (i / 32)) % 2 == 1) ? 8'hAA : 8'h55;
            we0 = 1'b1; wa0 = 10'(i); wd0 = img0[i];
            we2 = 1'b1; wa2 = 10'(i); wd2 = img2[i];
            @(negedge clk);
        end
        we0 = 1'b0; we2 = 1'b0;
    endtask

    task automatic test_stream_gap0();
        int dk, st; logic [15:0] rc; logic te, bz;
        stream0("t1", 0, -1, 1030, 1'b0, dk, rc, te, bz, st);
        checks++;
        if (dk !== 1031 || st !== 1) begin
            errors++;
            $display("FAIL t1_done done_k=%0d starts=%0d exp 1031/1", dk, st);
        end
        checks++;
        if (rc !== 16'd0 || te !== 1'b0 || bz !== 1'b0) begin
            errors++;
            $display("FAIL t1_status rc=%0d te=%b busy=%b exp 0/0/0", rc, te, bz);
        end
    endtask

    task automatic test_results();
        int dk = -1; logic [15:0] rc = '0; logic te = 1'b0, bz = 1'b1;
        @(negedge clk);
        go0 = 1'b1;
        for (int k = 1; k <= 1300 && dk < 0; k++) begin
            @(negedge clk);
            go0 = 1'b0;
            if (fd0 === 1'b1) begin
                dk = k; rc = rc0; te = te0; bz = busy0;
            end
            rv0 = (k <= 880) || (k >= 1030 && k <= 1068 && ((k - 1030) % 2 == 0));
        end
        rv0 = 1'b0;
        checks++;
        if (dk !== 1069) begin
            errors++;
            $display("FAIL t2_done_cycle got=%0d exp=1069", dk);
        end
        checks++;
        if (rc !== 16'd900) begin
            errors++;
            $display("FAIL t2_res_count got=%0d exp=900", rc);
        end
        checks++;
        if (te !== 1'b0 || bz !== 1'b0) begin
            errors++;
            $display("FAIL t2_status te=%b busy=%b exp 0/0", te, bz);
        end
        @(negedge clk);
        checks++;
        if (fd0 !== 1'b0 || rc0 !== 16'd900) begin
            errors++;
            $display("FAIL t2_hold frame_done=%b rc=%0d exp 0/900", fd0, rc0);
        end
    endtask

    task automatic test_timeout();
        int dk, st; logic [15:0] rc; logic te, bz;
        stream0("t4", 0, -1, -1, 1'b0, dk, rc, te, bz, st);
        checks++;
        if (dk !== 1090) begin
            errors++;
            $display("FAIL t4_done_cycle got=%0d exp=1090", dk);
        end
        checks++;
        if (te !== 1'b1 || rc !== 16'd0) begin
            errors++;
            $display("FAIL t4_status te=%b rc=%0d exp 1/0", te, rc);
        end
        @(negedge clk);
        checks++;
        if (te0 !== 1'b1 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL t4_hold te=%b busy=%b exp 1/0", te0, busy0);
        end
    endtask

    task automatic test_reset_mid();
        int dk, st, pv_seen; logic [15:0] rc; logic te, bz;
        go0 = 1'b1;
        for (int k = 1; k <= 502; k++) begin
            @(negedge clk);
            go0 = 1'b0;
            if (k == 1) begin
                checks++;
                if (te0 !== 1'b0) begin
                    errors++;
                    $display("FAIL t5_te_clear got=%b exp=0", te0);
                end
            end
            rv0 = (k <= 20);
        end
        checks++;
        if (pv0 !== 1'b1 || pi0 !== img0[500] || rc0 !== 16'd20) begin
            errors++;
            $display("FAIL t5_pre v=%b d=%h rc=%0d exp 1/%h/20", pv0, pi0, rc0, img0[500]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy0, fd0, te0, st0, pv0, pi0, rc0} !== 29'd0) begin
            errors++;
            $display("FAIL t5_after_rst got=%h exp=0", {busy0, fd0, te0, st0, pv0, pi0, rc0});
        end
        pv_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (pv0 !== 1'b0 || busy0 !== 1'b0) pv_seen++;
        end
        checks++;
        if (pv_seen !== 0) begin
            errors++;
            $display("FAIL t5_no_resume active_cycles=%0d exp=0", pv_seen);
        end
        stream0("t5", 0, -1, 1030, 1'b0, dk, rc, te, bz, st);
        checks++;
        if (dk !== 1031 || st !== 1) begin
            errors++;
            $display("FAIL t5_restream done_k=%0d starts=%0d exp 1031/1", dk, st);
        end
    endtask

    task automatic test_busy_ignore();
        int dk, st; logic [15:0] rc; logic te, bz;
        stream0("t6", 10, 19, 1030, 1'b1, dk, rc, te, bz, st);
        checks++;
        if (dk !== 1031 || st !== 1) begin
            errors++;
            $display("FAIL t6_done done_k=%0d starts=%0d exp 1031/1", dk, st);
        end
        checks++;
        if (rc !== 16'd10 || te !== 1'b0) begin
            errors++;
            $display("FAIL t6_status rc=%0d te=%b exp 10/0", rc, te);
        end
        stream0("t6b", 0, -1, 1030, 1'b0, dk, rc, te, bz, st);
        checks++;
        if (dk !== 1031) begin
            errors++;
            $display("FAIL t6b_done got=%0d exp=1031", dk);
        end
    endtask

    task automatic test_gap2();
        int dk = -1, vcnt = 0, last_k = -1;
        logic exp_v; logic [7:0] exp_p; logic te = 1'b0; logic [15:0] rc = '1;
        @(negedge clk);
        go2 = 1'b1;
        for (int k = 1; k <= 3300 && dk < 0; k++) begin
            @(negedge clk);
            go2 = 1'b0;
            checks++;
            if (st2 !== (k == 1)) begin
                errors++;
                $display("FAIL t3 start k=%0d got=%b exp=%b", k, st2, (k == 1));
            end
            exp_v = (k >= 2) && ((k - 2) % 3 == 0) && ((k - 2) / 3 < NP);
            exp_p = 8'h00;
            if (exp_v) exp_p = img2[(k-2)/3];
            checks++;
            if (pv2 !== exp_v || pi2 !== exp_p) begin
                errors++;
                $display("FAIL t3 pixel k=%0d got v=%b d=%h exp v=%b d=%h", k, pv2, pi2, exp_v, exp_p);
            end
            if (pv2 === 1'b1) begin
                vcnt++; last_k = k;
            end
            if (fd2 === 1'b1) begin
                dk = k; te = te2; rc = rc2;
            end
        end
        checks++;
        if (vcnt !== NP || last_k !== 3071) begin
            errors++;
            $display("FAIL t3_count pulses=%0d last=%0d exp 1024/3071", vcnt, last_k);
        end
        checks++;
        if (dk !== 3136 || te !== 1'b1 || rc !== 16'd0) begin
            errors++;
            $display("FAIL t3_timeout done_k=%0d te=%b rc=%0d exp 3136/1/0", dk, te, rc);
        end
    endtask

    initial begin
        test_reset();
        load_bufs();
        test_stream_gap0();
        test_results();
        test_timeout();
        test_reset_mid();
        test_busy_ignore();
        test_gap2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
